// File: rtl/peg_l2_params.sv
// Shared L2 constants and types for the RMII reconciliation sub-layer.
package peg_l2_params;

    localparam logic [55:0] PREAMBLE_VALUE  = {7{8'h55}};
    localparam logic [7:0]  SFD_VALUE       = 8'hD5;
    localparam logic [63:0] PREAMBLE_SFD    = {SFD_VALUE, PREAMBLE_VALUE};
    localparam int          PREAMBLE_DIBITS = 32;
    localparam int          RMII_10M_DIV    = 10;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        DATA,
        DRAIN,
        IFG
    } rmii_tx_fsm_t;

endpackage

// File: rtl/peg_l2_rs_rmii_tick_gen.sv
// Dibit-rate strobe for RMII: every clock at 100M, every 10th clock at 10M.
// The speed select is sampled only while clear is held (the idle state).
module peg_l2_rs_rmii_tick_gen
    import peg_l2_params::*;
(
    input  logic rmii_ref_clk,
    input  logic rst,
    input  logic speed_100_n_10,
    input  logic clear,
    output logic dibit_tick
);

    localparam int             DIV_W    = $clog2(RMII_10M_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RMII_10M_DIV - 1);

    logic             speed_reg;
    logic [DIV_W-1:0] div_cnt_reg;

    always_ff @(posedge rmii_ref_clk or posedge rst) begin
        if (rst) begin
            speed_reg   <= 1'b0;
            div_cnt_reg <= '0;
        end else if (clear) begin
            speed_reg   <= speed_100_n_10;
            div_cnt_reg <= '0;
        end else if (div_cnt_reg == DIV_LAST) begin
            div_cnt_reg <= '0;
        end else begin
            div_cnt_reg <= div_cnt_reg + DIV_W'(1);
        end
    end

    assign dibit_tick = !clear && (speed_reg || (div_cnt_reg == DIV_LAST));

endmodule

// File: rtl/peg_l2_rs_rmii_tx.sv
// RMII transmit reconciliation: serialises MAC words onto TXD/TX_EN with
// preamble+SFD, truncation on underrun/error, and inter-frame gap enforcement.
module peg_l2_rs_rmii_tx
    import peg_l2_params::*;
#(
    parameter  int PKT_DATA_W = 64,
    parameter  int IFG_DIBITS = 48,
    localparam int BCNT_W     = $clog2(PKT_DATA_W / 8)
) (
    input  logic                  rmii_ref_clk,
    input  logic                  rst,
    input  logic                  config_rs_mii_speed_100_n_10,
    input  logic                  pkt_valid,
    input  logic                  pkt_sop,
    input  logic                  pkt_eop,
    input  logic [BCNT_W-1:0]     pkt_bytes,
    input  logic [PKT_DATA_W-1:0] pkt_data,
    input  logic                  pkt_error,
    output logic                  pkt_ready,
    output logic                  rmii_tx_en,
    output logic [1:0]            rmii_txd,
    output logic                  tx_underrun,
    output logic                  tx_abort
);

    localparam int WORD_DIBITS = PKT_DATA_W / 2;
    localparam int CNT_W = $clog2((WORD_DIBITS > PREAMBLE_DIBITS) ? WORD_DIBITS : PREAMBLE_DIBITS);
    localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(WORD_DIBITS - 1);
    localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PREAMBLE_DIBITS - 1);
    localparam int IFG_W = $clog2(IFG_DIBITS + 1);
    localparam logic [IFG_W-1:0] IFG_LAST  = IFG_W'(IFG_DIBITS - 1);

    rmii_tx_fsm_t          state_reg, state_next;
    logic [PKT_DATA_W-1:0] data_sr_reg, data_sr_next;
    logic [CNT_W-1:0]      cnt_reg, cnt_next;
    logic [CNT_W-1:0]      last_idx_reg, last_idx_next;
    logic                  eop_word_reg, eop_word_next;
    logic [IFG_W-1:0]      ifg_cnt_reg, ifg_cnt_next;
    logic                  tx_en_reg, tx_en_next;
    logic [1:0]            txd_reg, txd_next;
    logic                  underrun_reg, underrun_next;
    logic                  abort_reg, abort_next;
    logic                  ready_int;
    logic                  dibit_tick;
    logic [CNT_W-1:0]      pre_idx;

    // Index of the final dibit of a word: short eop words stop after pkt_bytes bytes.
    function automatic logic [CNT_W-1:0] word_last_idx(input logic eop, input logic [BCNT_W-1:0] nbytes);
        logic [CNT_W-1:0] n;
        n = CNT_W'({nbytes, 2'b00});
        if (eop && (nbytes != '0))
            return n - CNT_W'(1);
        return WORD_LAST;
    endfunction

    peg_l2_rs_rmii_tick_gen u_tick_gen (
        .rmii_ref_clk   (rmii_ref_clk),
        .rst            (rst),
        .speed_100_n_10 (config_rs_mii_speed_100_n_10),
        .clear          (state_reg == IDLE),
        .dibit_tick     (dibit_tick)
    );

    always_ff @(posedge rmii_ref_clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            data_sr_reg  <= '0;
            cnt_reg      <= '0;
            last_idx_reg <= '0;
            eop_word_reg <= 1'b0;
            ifg_cnt_reg  <= '0;
            tx_en_reg    <= 1'b0;
            txd_reg      <= 2'b00;
            underrun_reg <= 1'b0;
            abort_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            data_sr_reg  <= data_sr_next;
            cnt_reg      <= cnt_next;
            last_idx_reg <= last_idx_next;
            eop_word_reg <= eop_word_next;
            ifg_cnt_reg  <= ifg_cnt_next;
            tx_en_reg    <= tx_en_next;
            txd_reg      <= txd_next;
            underrun_reg <= underrun_next;
            abort_reg    <= abort_next;
        end
    end

    // txd_reg always holds the dibit currently on the wire; each tick retires it
    // and presents the next one.
    always_comb begin
        state_next    = state_reg;
        data_sr_next  = data_sr_reg;
        cnt_next      = cnt_reg;
        last_idx_next = last_idx_reg;
        eop_word_next = eop_word_reg;
        ifg_cnt_next  = ifg_cnt_reg;
        tx_en_next    = tx_en_reg;
        txd_next      = txd_reg;
        underrun_next = 1'b0;
        abort_next    = 1'b0;
        ready_int     = 1'b0;
        pre_idx       = cnt_reg + CNT_W'(1);

        case (state_reg)
            IDLE: begin
                ready_int  = 1'b1;
                tx_en_next = 1'b0;
                txd_next   = 2'b00;
                cnt_next   = '0;
                if (pkt_valid && pkt_sop) begin
                    if (pkt_error) begin
                        abort_next = 1'b1;
                    end else begin
                        state_next    = PREAMBLE;
                        data_sr_next  = pkt_data;
                        last_idx_next = word_last_idx(pkt_eop, pkt_bytes);
                        eop_word_next = pkt_eop;
                        tx_en_next    = 1'b1;
                        txd_next      = PREAMBLE_SFD[1:0];
                    end
                end
            end

            PREAMBLE: begin
                if (dibit_tick) begin
                    if (cnt_reg == PRE_LAST) begin
                        state_next = DATA;
                        cnt_next   = '0;
                        txd_next   = data_sr_reg[1:0];
                    end else begin
                        cnt_next = pre_idx;
                        txd_next = PREAMBLE_SFD[{pre_idx, 1'b0} +: 2];
                    end
                end
            end

            DATA: begin
                if (dibit_tick) begin
                    if (cnt_reg != last_idx_reg) begin
                        data_sr_next = data_sr_reg >> 2;
                        txd_next     = data_sr_reg[3:2];
                        cnt_next     = cnt_reg + CNT_W'(1);
                    end else if (eop_word_reg) begin
                        state_next   = IFG;
                        ifg_cnt_next = '0;
                        tx_en_next   = 1'b0;
                        txd_next     = 2'b00;
                    end else begin
                        ready_int = 1'b1;
                        if (!pkt_valid) begin
                            underrun_next = 1'b1;
                            state_next    = DRAIN;
                            tx_en_next    = 1'b0;
                            txd_next      = 2'b00;
                        end else if (pkt_error || pkt_sop) begin
                            // A stray sop mid-frame is handled like an error: the new packet is discarded.
                            abort_next   = 1'b1;
                            state_next   = pkt_eop ? IFG : DRAIN;
                            ifg_cnt_next = '0;
                            tx_en_next   = 1'b0;
                            txd_next     = 2'b00;
                        end else begin
                            data_sr_next  = pkt_data;
                            txd_next      = pkt_data[1:0];
                            cnt_next      = '0;
                            last_idx_next = word_last_idx(pkt_eop, pkt_bytes);
                            eop_word_next = pkt_eop;
                        end
                    end
                end
            end

            DRAIN: begin
                ready_int  = 1'b1;
                tx_en_next = 1'b0;
                txd_next   = 2'b00;
                if (pkt_valid && pkt_eop) begin
                    state_next   = IFG;
                    ifg_cnt_next = '0;
                end
            end

            IFG: begin
                tx_en_next = 1'b0;
                txd_next   = 2'b00;
                if (dibit_tick) begin
                    if (ifg_cnt_reg == IFG_LAST)
                        state_next = IDLE;
                    else
                        ifg_cnt_next = ifg_cnt_reg + IFG_W'(1);
                end
            end

            default: begin
                state_next = IDLE;
                tx_en_next = 1'b0;
                txd_next   = 2'b00;
            end
        endcase
    end

    assign pkt_ready   = ready_int && !rst;
    assign rmii_tx_en  = tx_en_reg;
    assign rmii_txd    = txd_reg;
    assign tx_underrun = underrun_reg;
    assign tx_abort    = abort_reg;

endmodule

// File: tb/tb_peg_l2_rs_rmii_tx.sv
// Bench for the RMII TX reconciliation block: table of packet scenarios plus
// randomized packets, checked against a byte/dibit-level frame model.
module tb_peg_l2_rs_rmii_tx;

    localparam int W   = 64;
    localparam int BW  = 3;
    localparam int IFG = 48;
    localparam int F_NONE  = 0;
    localparam int F_UNDER = 1;
    localparam int F_ERR   = 2;
    localparam int F_SOP   = 3;

    typedef struct {
        bit spd100;
        int nwords;
        int bytes;
        int fault;
        int fword;
        int exp_dibits;   // -1: take the length from the model
        int exp_und;
        int exp_abt;
        int exp_rdy;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          speed;
    logic          pkt_valid, pkt_sop, pkt_eop, pkt_error;
    logic [BW-1:0] pkt_bytes;
    logic [W-1:0]  pkt_data;
    logic          pkt_ready, rmii_tx_en, tx_underrun, tx_abort;
    logic [1:0]    rmii_txd;

    int n_checks = 0;
    int n_fail   = 0;
    int und_cnt  = 0;
    int abt_cnt  = 0;
    int txd_viol = 0;
    int rdy_cnt;
    logic [1:0] cap_q[$];
    logic [1:0] exp_q[$];
    logic [W-1:0] words [8];
    vec_t vecs [10];

    always #10 clk = ~clk;

    peg_l2_rs_rmii_tx #(.PKT_DATA_W(W), .IFG_DIBITS(IFG)) dut (
        .rmii_ref_clk                 (clk),
        .rst                          (rst),
        .config_rs_mii_speed_100_n_10 (speed),
        .pkt_valid                    (pkt_valid),
        .pkt_sop                      (pkt_sop),
        .pkt_eop                      (pkt_eop),
        .pkt_bytes                    (pkt_bytes),
        .pkt_data                     (pkt_data),
        .pkt_error                    (pkt_error),
        .pkt_ready                    (pkt_ready),
        .rmii_tx_en                   (rmii_tx_en),
        .rmii_txd                     (rmii_txd),
        .tx_underrun                  (tx_underrun),
        .tx_abort                     (tx_abort)
    );

    always @(negedge clk) begin
        if (tx_underrun === 1'b1) und_cnt++;
        if (tx_abort === 1'b1) abt_cnt++;
        if (rmii_tx_en !== 1'b1 && rmii_txd !== 2'b00) txd_viol++;
    end

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic check_range(input string name, input longint act, input longint lo, input longint hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Frame model: 31 x 01 then 11, then every transmitted byte LSB dibit first.
    task automatic build_expected(input int nwords, input int bytes, input int fault, input int fword);
        int sent;
        int nb;
        logic [7:0] byt;
        exp_q.delete();
        sent = (fault == F_NONE) ? nwords : fword;
        if (sent == 0) return;
        for (int i = 0; i < 31; i++) exp_q.push_back(2'b01);
        exp_q.push_back(2'b11);
        for (int w = 0; w < sent; w++) begin
            nb = (fault == F_NONE && w == nwords - 1 && bytes != 0) ? bytes : W / 8;
            for (int b = 0; b < nb; b++) begin
                byt = 8'((words[w] >> (8 * b)) & 64'hFF);
                for (int j = 0; j < 4; j++) exp_q.push_back(2'((byt >> (2 * j)) & 8'h3));
            end
        end
    endtask

    task automatic drive_pkt(input int nwords, input int bytes, input int fault, input int fword);
        for (int i = 0; i < nwords; i++) begin
            bit acc;
            int t;
            if (fault == F_UNDER && i == fword) begin
                pkt_valid = 1'b0;
                repeat (speed ? 150 : 1500) @(negedge clk);
            end
            pkt_valid = 1'b1;
            pkt_sop   = (i == 0) || (fault == F_SOP && i == fword);
            pkt_eop   = (i == nwords - 1);
            pkt_bytes = pkt_eop ? BW'(bytes) : BW'($urandom);
            pkt_error = (fault == F_ERR && i == fword);
            pkt_data  = words[i];
            acc = 1'b0;
            t = 0;
            while (!acc && t < 5000) begin
                #1 acc = pkt_ready;
                @(posedge clk);
                @(negedge clk);
                t++;
            end
            if (!acc) check("accept_timeout", 0, 1);
        end
        pkt_valid = 1'b0;
        pkt_sop   = 1'b0;
        pkt_eop   = 1'b0;
        pkt_error = 1'b0;
    endtask

    task automatic collect(input int max_wait, output bit got);
        int w;
        w = 0;
        got = 1'b0;
        cap_q.delete();
        rdy_cnt = 0;
        @(negedge clk);
        while (!rmii_tx_en && w < max_wait) begin
            @(negedge clk);
            w++;
        end
        if (!rmii_tx_en) return;
        got = 1'b1;
        while (rmii_tx_en && w < 20000) begin
            cap_q.push_back(rmii_txd);
            if (pkt_ready) rdy_cnt++;
            @(negedge clk);
            w++;
        end
        if (rmii_tx_en) check("frame_end_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (!(pkt_ready && !rmii_tx_en) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 5000) check("idle_timeout", 0, 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic run_vec(input int id, input vec_t v);
        bit got;
        int div, len, mism, u0, a0;
        speed = v.spd100;
        wait_idle();
        build_expected(v.nwords, v.bytes, v.fault, v.fword);
        len = (v.exp_dibits < 0) ? exp_q.size() : v.exp_dibits;
        div = v.spd100 ? 1 : 10;
        u0 = und_cnt;
        a0 = abt_cnt;
        fork
            drive_pkt(v.nwords, v.bytes, v.fault, v.fword);
            collect((len == 0) ? 200 : 500, got);
        join
        wait_idle();
        mism = 0;
        for (int i = 0; i < cap_q.size(); i++)
            if (i / div >= exp_q.size() || cap_q[i] !== exp_q[i / div]) mism++;
        $display("pkt %0d: spd100=%0d words=%0d bytes=%0d fault=%0d clks_en=%0d exp_dibits=%0d",
                 id, v.spd100, v.nwords, v.bytes, v.fault, cap_q.size(), len);
        check($sformatf("pkt%0d_frame_seen", id), got, len != 0);
        check($sformatf("pkt%0d_txen_clks", id), cap_q.size(), len * div);
        check($sformatf("pkt%0d_dibit_mism", id), mism, 0);
        check($sformatf("pkt%0d_underrun", id), und_cnt - u0, v.exp_und);
        check($sformatf("pkt%0d_abort", id), abt_cnt - a0, v.exp_abt);
        check($sformatf("pkt%0d_ready_in_frame", id), rdy_cnt, v.exp_rdy);
    endtask

    task automatic ifg_test(input bit spd);
        bit got;
        int gap, hi, div;
        div = spd ? 1 : 10;
        speed = spd;
        wait_idle();
        words[0] = {$urandom, $urandom};
        fork
            begin
                drive_pkt(1, 0, F_NONE, 0);
                drive_pkt(1, 0, F_NONE, 0);
            end
            begin
                collect(500, got);
                gap = 1;
                while (!rmii_tx_en && gap < 3000) begin
                    @(negedge clk);
                    if (!rmii_tx_en) gap++;
                end
                hi = 0;
                while (rmii_tx_en && hi < 3000) begin
                    hi++;
                    @(negedge clk);
                end
            end
        join
        $display("ifg spd100=%0d: gap_clks=%0d second_frame_clks=%0d", spd, gap, hi);
        check_range($sformatf("ifg_gap_spd%0d", spd), gap, IFG * div, IFG * div + 1);
        check($sformatf("ifg_second_frame_spd%0d", spd), hi, 64 * div);
    endtask

    initial begin
        int u0;
        vec_t v;
        rst = 1'b1;
        speed = 1'b1;
        pkt_valid = 1'b0; pkt_sop = 1'b0; pkt_eop = 1'b0; pkt_error = 1'b0;
        pkt_bytes = '0;
        pkt_data = '0;

        vecs[0] = '{1, 1, 0, F_NONE, 0, 64, 0, 0, 0};
        vecs[1] = '{1, 3, 3, F_NONE, 0, 108, 0, 0, 2};
        vecs[2] = '{0, 1, 0, F_NONE, 0, 64, 0, 0, 0};
        vecs[3] = '{1, 3, 0, F_UNDER, 1, 64, 1, 0, 1};
        vecs[4] = '{1, 3, 0, F_ERR, 1, 64, 0, 1, 1};
        vecs[5] = '{1, 2, 1, F_NONE, 0, 68, 0, 0, 1};
        vecs[6] = '{1, 1, 7, F_NONE, 0, 60, 0, 0, 0};
        vecs[7] = '{0, 2, 5, F_NONE, 0, 84, 0, 0, 1};
        vecs[8] = '{1, 3, 0, F_SOP, 1, 64, 0, 1, 1};
        vecs[9] = '{1, 1, 0, F_ERR, 0, 0, 0, 1, 0};

        repeat (3) @(negedge clk);
        check("rst_txen", rmii_tx_en, 0);
        check("rst_txd", rmii_txd, 0);
        check("rst_ready", pkt_ready, 0);
        check("rst_underrun", tx_underrun, 0);
        check("rst_abort", tx_abort, 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", pkt_ready, 1);

        for (int i = 0; i < 10; i++) begin
            for (int k = 0; k < 8; k++) words[k] = {$urandom, $urandom};
            if (i == 0) words[0] = 64'h0123_4567_89AB_CDEF;
            run_vec(i, vecs[i]);
            if (i == 0 && cap_q.size() > 35) begin
                check("pkt0_sfd_dibit", cap_q[31], 3);
                check("pkt0_first_data_dibit", cap_q[32], 3);
                check("pkt0_third_data_dibit", cap_q[34], 2);
            end
        end

        for (int r = 0; r < 12; r++) begin
            v.spd100 = ($urandom_range(0, 3) != 0);
            v.nwords = $urandom_range(1, 4);
            v.bytes  = $urandom_range(0, 7);
            v.fault  = (v.nwords > 1) ? $urandom_range(0, 3) : F_NONE;
            v.fword  = (v.fault != F_NONE) ? $urandom_range(1, v.nwords - 1) : 0;
            v.exp_dibits = -1;
            v.exp_und = (v.fault == F_UNDER) ? 1 : 0;
            v.exp_abt = (v.fault == F_ERR || v.fault == F_SOP) ? 1 : 0;
            v.exp_rdy = (v.fault == F_NONE) ? v.nwords - 1 : v.fword;
            for (int k = 0; k < 8; k++) words[k] = {$urandom, $urandom};
            run_vec(100 + r, v);
        end

        ifg_test(1'b1);
        ifg_test(1'b0);

        // Reset in the middle of the data phase.
        speed = 1'b1;
        wait_idle();
        pkt_valid = 1'b1; pkt_sop = 1'b1; pkt_eop = 1'b0; pkt_error = 1'b0;
        pkt_data = {$urandom, $urandom};
        @(posedge clk);
        @(negedge clk);
        pkt_valid = 1'b0; pkt_sop = 1'b0;
        repeat (40) @(negedge clk);
        check("midrst_txen_before", rmii_tx_en, 1);
        rst = 1'b1;
        #1;
        check("midrst_txen", rmii_tx_en, 0);
        check("midrst_txd", rmii_txd, 0);
        check("midrst_ready", pkt_ready, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        $display("midrst: ready=%0d tx_en=%0d after release", pkt_ready, rmii_tx_en);
        check("midrst_ready_after", pkt_ready, 1);
        check("midrst_txen_after", rmii_tx_en, 0);
        u0 = und_cnt;
        repeat (100) @(negedge clk);
        check("midrst_no_underrun", und_cnt - u0, 0);
        check("midrst_txen_stays_low", rmii_tx_en, 0);

        check("txd_zero_when_txen_low", txd_viol, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
